// File: rtl/register_arbiter_if.sv
// ----------------------------------------------------------------------------
// register_arbiter_if
//
// Bundles every signal that crosses the register_arbiter boundary other than
// clock and reset: the two requester ports and the link to the 16 x 8
// register unit.
//
// Modports
//   slave  : the arbiter's view. It takes in the requests and the register
//            unit's data_out, and drives the acks, read data and register
//            unit controls.
//   master : the environment's view (the requesters plus the register unit).
//
// Signals
//   req0/we0/addr0/wdata0    port 0 request, write enable, address, write data
//   ack0/rdata0              port 0 completion pulse and read data
//   req1/we1/addr1/wdata1    port 1, same roles as port 0
//   ack1/rdata1              port 1, same roles as port 0
//   reg_load/reg_addr/
//   reg_data_in              controls driven into the register unit
//   reg_data_out             registered read data from the register unit
// ----------------------------------------------------------------------------
interface register_arbiter_if #(
    parameter int REG_COUNT = 16,
    parameter int REG_SIZE  = 8,
    parameter int ADDR_W    = $clog2(REG_COUNT)
);
    logic                req0;
    logic                we0;
    logic [ADDR_W-1:0]   addr0;
    logic [REG_SIZE-1:0] wdata0;
    logic                ack0;
    logic [REG_SIZE-1:0] rdata0;

    logic                req1;
    logic                we1;
    logic [ADDR_W-1:0]   addr1;
    logic [REG_SIZE-1:0] wdata1;
    logic                ack1;
    logic [REG_SIZE-1:0] rdata1;

    logic                reg_load;
    logic [ADDR_W-1:0]   reg_addr;
    logic [REG_SIZE-1:0] reg_data_in;
    logic [REG_SIZE-1:0] reg_data_out;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  reg_data_out,
        output ack0, rdata0, ack1, rdata1,
        output reg_load, reg_addr, reg_data_in
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output reg_data_out,
        input  ack0, rdata0, ack1, rdata1,
        input  reg_load, reg_addr, reg_data_in
    );
endinterface

// File: rtl/register_arbiter.sv
// ----------------------------------------------------------------------------
// register_arbiter
//
// Two-port arbiter and sequencer in front of the 16 x 8 register unit. One
// request is granted at a time and walked through the sequence
// IDLE -> ISSUE -> CAPTURE -> RESP, so every transaction takes four cycles.
// The granted port receives a one-cycle ack; for reads, the matching rdata
// is valid during that ack.
//
// Ports
//   clock  : system clock, all logic on posedge
//   reset  : synchronous, active-low
//   bus    : register_arbiter_if.slave (requester ports + register unit link)
//   busy   : high whenever the sequencer is not in IDLE
//
// Build option
//   REG_ARB_FIXED_PRIORITY_EN : when defined, port 0 always wins a tie and no
//   last-winner history is kept. When undefined (the default), ties go
//   round-robin to the port that was not served last.
// ----------------------------------------------------------------------------
module register_arbiter #(
    parameter int REG_COUNT = 16,
    parameter int REG_SIZE  = 8,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clock,
    input  logic              reset,
    register_arbiter_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t              state;
    state_t              next_state;

    // Port and direction of the transaction in flight.
    logic                act_port;
    logic                act_port_d;
    logic                act_we;
    logic                act_we_d;

    logic                ack0_q;
    logic                ack0_d;
    logic                ack1_q;
    logic                ack1_d;
    logic [REG_SIZE-1:0] rdata0_q;
    logic [REG_SIZE-1:0] rdata0_d;
    logic [REG_SIZE-1:0] rdata1_q;
    logic [REG_SIZE-1:0] rdata1_d;
    logic                reg_load_q;
    logic                reg_load_d;
    logic [ADDR_W-1:0]   reg_addr_q;
    logic [ADDR_W-1:0]   reg_addr_d;
    logic [REG_SIZE-1:0] reg_data_in_q;
    logic [REG_SIZE-1:0] reg_data_in_d;
    logic                busy_q;
    logic                busy_d;

    logic                any_req;
    logic                grant_port;

    assign any_req = bus.req0 | bus.req1;

`ifdef REG_ARB_FIXED_PRIORITY_EN
    // Port 0 wins whenever it is requesting.
    assign grant_port = ~bus.req0;
`else
    logic                last_winner;
    logic                last_winner_d;

    // On a tie, the port that was not served last wins. A lone requester
    // always wins.
    assign grant_port = (bus.req0 & bus.req1) ? ~last_winner : bus.req1;
`endif

    // State register plus all registered outputs. Reset sets every output
    // to zero and abandons any transaction in flight without an ack. The
    // register unit is not reset, so a write already issued still lands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            act_port      <= 1'b0;
            act_we        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            reg_load_q    <= 1'b0;
            reg_addr_q    <= '0;
            reg_data_in_q <= '0;
            busy_q        <= 1'b0;
`ifndef REG_ARB_FIXED_PRIORITY_EN
            last_winner   <= 1'b1;
`endif
        end else begin
            state         <= next_state;
            act_port      <= act_port_d;
            act_we        <= act_we_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            reg_load_q    <= reg_load_d;
            reg_addr_q    <= reg_addr_d;
            reg_data_in_q <= reg_data_in_d;
            busy_q        <= busy_d;
`ifndef REG_ARB_FIXED_PRIORITY_EN
            last_winner   <= last_winner_d;
`endif
        end
    end

    // Next-state logic. Only IDLE waits; the other three states always
    // last exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs. The winner's request is copied
    // once in IDLE. After that, reg_addr/reg_data_in hold the transaction,
    // so any later change on the request inputs is ignored. The ack is
    // raised at the edge that closes CAPTURE. The default of zero drops it
    // again at the edge that closes RESP.
    always_comb begin
        act_port_d    = act_port;
        act_we_d      = act_we;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        reg_load_d    = 1'b0;
        reg_addr_d    = reg_addr_q;
        reg_data_in_d = reg_data_in_q;
        busy_d        = (next_state != IDLE);
`ifndef REG_ARB_FIXED_PRIORITY_EN
        last_winner_d = last_winner;
`endif

        case (state)
            IDLE: begin
                if (any_req) begin
                    act_port_d    = grant_port;
                    act_we_d      = grant_port ? bus.we1 : bus.we0;
                    reg_addr_d    = grant_port ? bus.addr1 : bus.addr0;
                    reg_data_in_d = grant_port ? bus.wdata1 : bus.wdata0;
                    reg_load_d    = act_we_d;
`ifndef REG_ARB_FIXED_PRIORITY_EN
                    last_winner_d = grant_port;
`endif
                end
            end
            CAPTURE: begin
                // The register unit's data_out now reflects the addressed
                // slot. Only a read updates the winner's rdata.
                if (act_port) begin
                    ack1_d = 1'b1;
                    if (!act_we) rdata1_d = bus.reg_data_out;
                end else begin
                    ack0_d = 1'b1;
                    if (!act_we) rdata0_d = bus.reg_data_out;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.reg_load    = reg_load_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_data_in = reg_data_in_q;
    assign busy            = busy_q;

endmodule

// File: doc/register_arbiter.md
Name: register_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16 x 8 register unit.
- Accepts read/write requests from two requesters (port 0, e.g. instruction loader; port 1, e.g. ALU writeback) and grants one at a time, round-robin.
- Drives the register unit's addr/load/data_in, captures its registered data_out, and returns data with a one-cycle ack per transaction.

Parameters:
REG_COUNT, 16, number of register slots
REG_SIZE, 8, data width in bits
ADDR_W, 4, address width (log2 REG_COUNT)

Ports:
clock  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
req0  input  1  port 0 request; held high until ack0 is sampled
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  ADDR_W  port 0 register address
wdata0  input  REG_SIZE  port 0 write data
ack0  output  1  port 0 completion pulse, one cycle
rdata0  output  REG_SIZE  port 0 read data, valid while ack0=1
req1/we1/addr1/wdata1/ack1/rdata1  same as port 0, for port 1
reg_load  output  1  to register unit load
reg_addr  output  ADDR_W  to register unit addr
reg_data_in  output  REG_SIZE  to register unit data_in
reg_data_out  input  REG_SIZE  from register unit data_out
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All outputs are registered.
- IDLE:
  - If any req is high at the posedge, pick a winner and latch its we/addr/wdata.
  - Load reg_addr/reg_data_in and set reg_load=we. Go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port not served last wins.
  - last_winner resets to 1, so port 0 wins the first tie.
  - last_winner updates on entry to ISSUE.
- ISSUE (one cycle): reg_load equals the latched we. The register unit writes, or updates its data_out, at the closing edge. Next state is CAPTURE. reg_load returns to 0 at that edge.
- CAPTURE (one cycle):
  - reg_addr is held; reg_data_out now reflects the addressed slot.
  - At the closing edge: ackN<=1. For reads, rdataN<=reg_data_out.
  - For writes, rdataN is unchanged. Next state is RESP.
- RESP (one cycle): ackN=1. At the closing edge ackN<=0 and the FSM goes to IDLE. The requester deasserts req at this edge.
- Latency: req sampled in IDLE at edge E0; ack is high in the cycle after E2. A single transaction occupies 4 cycles. Back-to-back throughput is one transaction per 4 cycles.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- A req dropped after being latched does not cancel the transaction; ack is still issued.
- req/we/addr/wdata changes after latching are ignored until the next IDLE.
- The non-winning requester keeps req high and is served in the next IDLE evaluation.
- The ack and rdata of the non-active port stay 0 and unchanged respectively.
- Reset (reset=0 at posedge), applied in any state:
  - state=IDLE, ack0=ack1=0, rdata0=rdata1=0, reg_load=0, reg_addr=0, reg_data_in=0, busy=0, last_winner=1.
  - Reset does not clear the register unit's contents.
  - A write whose ISSUE edge coincides with reset is still performed by the register unit. No ack is given for it.
  - Transactions in flight are abandoned without ack.

Optional Feature:
- Macro: REG_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; port 0 always wins ties and last_winner is not implemented.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req0=req1=1 -> ack0=ack1=0, busy=0, reg_load=0, rdata0=rdata1=0 throughout.
- Write then read, port 0: write addr0=5, wdata0=0xA7 -> ack0 high exactly 3 cycles after req sampled, reg_load high for exactly one cycle with reg_addr=5. Then read addr0=5 -> ack0 pulse with rdata0=0xA7.
- Simultaneous requests: req0 (write addr 2 = 0x11) and req1 (write addr 3 = 0x22) both held -> port 0 served first, then port 1; reading back gives 0x11 and 0x22.
- Continuous contention: both ports request continuously for 8 transactions -> grant order 0,1,0,1,... Under REG_ARB_FIXED_PRIORITY_EN, all 8 go to port 0 while req0 is held.
- Early req drop: req1 read of addr 9 (preloaded 0x3C) dropped the cycle after it is latched -> ack1 still pulses with rdata1=0x3C, and no second transaction starts.
- Reset mid-transaction: reset=0 asserted during CAPTURE of a port 0 read -> no ack0, FSM in IDLE next cycle, subsequent read of the same address completes normally.
